// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and default sizing.
package rr_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_binenc.sv
// Highest-index binary encoder: reports the index of the most significant set bit.
module rr_arbiter_binenc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         in_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        idx_o   = '0;
        valid_o = |in_i;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release, owner drop or hold limit.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_WIDTH,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 release_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    arb_state_e    state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  prio_mask;
    logic [N-1:0]  masked;
    logic [IW-1:0] masked_idx, req_idx, win_idx;
    logic          masked_any, req_any;
    logic          hold_at_limit;

    // Only indices strictly below the last owner outrank the plain highest-index pick.
    always_comb begin
        prio_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            prio_mask[i] = (IW'(i) < last_q);
        end
    end

    assign masked = req_i & prio_mask;

    rr_arbiter_binenc #(.N(N)) u_enc_masked (
        .in_i    (masked),
        .idx_o   (masked_idx),
        .valid_o (masked_any)
    );

    rr_arbiter_binenc #(.N(N)) u_enc_req (
        .in_i    (req_i),
        .idx_o   (req_idx),
        .valid_o (req_any)
    );

    assign win_idx       = masked_any ? masked_idx : req_idx;
    assign hold_at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    state_d = ARB_BUSY;
                    gnt_d   = ONE << win_idx;
                    idx_d   = win_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ARB_BUSY: begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
                // Release outranks both abort and timeout, so timeout only fires when neither ends the grant.
                if (release_i || !req_i[idx_q] || hold_at_limit) begin
                    state_d   = ARB_IDLE;
                    last_d    = idx_q;
                    gnt_d     = '0;
                    idx_d     = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    timeout_d = !release_i && req_i[idx_q];
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            last_q    <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with N=4, MAX_HOLD=4.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int unsigned total_cnt;
    int unsigned pass_cnt;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .release_i (rel),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic b, input logic t);
        chk({tag, ".gnt"},     32'(gnt),     32'(g));
        chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(i));
        chk({tag, ".busy"},    32'(busy),    32'(b));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rot_exp [5];
        rot_exp[0] = 2'd2; rot_exp[1] = 2'd1; rot_exp[2] = 2'd0;
        rot_exp[3] = 2'd3; rot_exp[4] = 2'd2;
        total_cnt = 0;
        pass_cnt  = 0;

        rst = 1'b1; req = 4'b0000; rel = 1'b0;
        #2;
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        #10 rst = 1'b0;
        tick();

        // Basic grant: highest index wins after reset, then release.
        req = 4'b1010;
        tick();
        chk_out("grant1010", 4'b1000, 2'd3, 1'b1, 1'b0);
        rel = 1'b1; req = 4'b0000;
        tick();
        chk_out("release1", 4'b0000, 2'd0, 1'b0, 1'b0);
        rel = 1'b0;
        tick();
        chk_out("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation with all requesting; last owner was 3.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rot%0d", k), 4'b0001 << rot_exp[k], rot_exp[k], 1'b1, 1'b0);
            rel = 1'b1;
            if (k == 4) req = 4'b0000;
            tick();
            chk($sformatf("rot%0d.gap_busy", k), 32'(busy), 32'd0);
            rel = 1'b0;
        end

        // Abort by owner dropping request; last owner was 2.
        req = 4'b1111;
        tick();
        chk_out("abort_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1101;
        tick();
        chk_out("abort_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("abort_next", 4'b0001, 2'd0, 1'b1, 1'b0);
        rel = 1'b1; req = 4'b0000;
        tick();
        rel = 1'b0;

        // Hold limit: four busy cycles then forced revoke with timeout pulse.
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_out($sformatf("hold_c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        tick();
        chk_out("hold_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Release coinciding with the hold limit suppresses timeout.
        tick();
        tick();
        tick();
        chk("coinc_busy_c4", 32'(busy), 32'd1);
        rel = 1'b1;
        tick();
        chk_out("coinc_end", 4'b0000, 2'd0, 1'b0, 1'b0);
        rel = 1'b0; req = 4'b0000;
        tick();
        chk("coinc_after_to", 32'(timeout), 32'd0);

        // Asynchronous reset mid-busy; last owner was 2, so requester 0 wins.
        req = 4'b0001;
        tick();
        chk_out("pre_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        req = 4'b1111;
        tick();
        chk_out("post_rst", 4'b1000, 2'd3, 1'b1, 1'b0);
        rel = 1'b1; req = 4'b0000;
        tick();
        chk_out("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release in IDLE has no effect.
        tick();
        chk_out("idle_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        rel = 1'b0;
        tick();
        chk_out("idle_rel_after", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111;
        tick();
        chk_out("idle_rel_next", 4'b0100, 2'd2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one single-owner resource (bus, datapath port, encoder input slot) among `N` requesters. It registers a one-hot grant plus its binary index, holds the grant until the owner releases it, drops its request, or exceeds a hold limit, then rotates priority so the last owner ranks lowest. It sits between requester blocks and the shared resource's select mux.

## Interface
- `N`, `` `DEFAULT_WIDTH ``: number of requesters, ≥ 2.
- `MAX_HOLD`, 16: maximum BUSY cycles per grant. 0 disables the limit.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `N`  level request per requester; held until served.
- `release`  in  1  owner finished; valid only in BUSY; ignored in IDLE.
- `gnt`  out  `N`  one-hot grant, registered; all zeros when idle.
- `gnt_idx`  out  `$clog2(N)`  binary index of the set `gnt` bit; 0 when idle.
- `busy`  out  1  high while a grant is active (`busy == |gnt`).
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State: FSM {IDLE, BUSY}, pointer `last[$clog2(N)-1:0]`, hold counter `hold_cnt` of width `$clog2(MAX_HOLD+1)`.
- Reset values: IDLE, `last`=0, `hold_cnt`=0, `gnt`=0, `gnt_idx`=0, `busy`=0, `timeout`=0.
- Arbitration is combinational in IDLE:
  - `masked = req & ((1<<last)-1)`.
  - If `masked` is non-zero, the winner is the highest set index of `masked`. Otherwise it is the highest set index of `req`.
  - Effective priority after granting k: k-1, k-2, …, 0, N-1, …, k.
  - After reset (`last`=0), the highest requesting index wins.
- IDLE → BUSY when `|req`: register `gnt`=1<<w, `gnt_idx`=w, `busy`=1, `hold_cnt`=0.
- In BUSY, `hold_cnt` increments every cycle, saturating at `MAX_HOLD`.
- BUSY → IDLE, in priority order. In all cases `gnt`/`gnt_idx`/`busy` clear on the same edge.
  1. `release`=1: normal end. Set `last`=`gnt_idx`.
  2. `req[gnt_idx]`=0: abort, treated as release. Set `last`=`gnt_idx`, no timeout.
  3. `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`-1: forced end. Set `last`=`gnt_idx` and pulse `timeout` for the following cycle.
- Simultaneous events:
  - If release and the timeout condition coincide, release wins and `timeout` stays 0.
  - Requests from other requesters during BUSY are queued implicitly. They are not sampled.
- `release` in IDLE, or a `req` change of a non-owner in BUSY, has no effect.
- Reset mid-BUSY: all outputs go to 0 immediately (asynchronous), and the pointer is reset.

## Timing
- Grant latency: `gnt` is asserted on the edge after the first cycle `req` is seen in IDLE (1 cycle).
- Release latency:
  - `gnt` is deasserted on the edge where `release` is sampled high.
  - Exactly one IDLE cycle follows before the next grant.
  - Back-to-back ownership turnaround is therefore 2 cycles.
- Maximum grant length is `MAX_HOLD` cycles of `busy`=1.
- Fairness: with all requesters continuously requesting, every requester is granted once per N grants.
- All outputs are registered. There is no combinational path from `req` or `release` to any output.

## Structure
- Shared package or `defines.v`:
  - state encoding constants `ARB_IDLE`/`ARB_BUSY`.
  - default `MAX_HOLD`.
  - reuse of `` `DEFAULT_WIDTH ``.
- Sub-module: reuse the codebase's highest-index binary encoder `binenc`, instantiated twice:
  - once on `masked`.
  - once on `req`.
  - A mux on `|masked` selects the winning index, and the one-hot grant is derived as `1<<idx`.
- Expected RTL size: about 150 lines.

## Test plan
Configuration for all scenarios: N=4, MAX_HOLD=4.
- Reset, then `req`=4'b1010 → next cycle `gnt`=4'b1000, `gnt_idx`=3, `busy`=1. `release` pulse → `gnt`=0 next edge.
- `req`=4'b1111 held, `release` pulsed each time `busy` is seen → grant order 3, 2, 1, 0, 3, with 1 idle cycle between grants.
- Owner drops `req` without `release` → `busy`=0 next edge, `timeout`=0, and the next grant skips the old owner.
- `req`=4'b0100 held, no `release` → `busy` high for 4 cycles, then `gnt`=0 and `timeout`=1 for 1 cycle. Next grant (only requester 2) is index 2 again.
- `release` and timeout condition in the same cycle → `timeout` stays 0.
- `rst` asserted mid-BUSY, between clock edges → `gnt`/`busy` go to 0 immediately. After deassert, `req`=4'b1111 grants index 3 (pointer reset). `release` pulsed in IDLE → no state change.
